// File: rtl/integrator_dec.sv
// ----------------------------------------------------------------------------
// integrator_dec
//   Decimating integrator stage of a CIC decimator. Every valid input sample is
//   added into a wrapping accumulator. Once per `decimation` valid samples, the
//   top DOUT_WIDTH bits of the updated sum are registered to dout. dout_valid
//   strobes for exactly one cycle alongside each new dout.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active low
//   din         signed input sample (DIN_WIDTH bits)
//   din_valid   qualifies din; no backpressure, one sample per clock allowed
//   clear       synchronous clear of accumulator and sample counter; wins over
//               din_valid
//   decimation  samples per output; 0 behaves as 1; may change at any time
//   dout        signed decimated output (DOUT_WIDTH bits), held between strobes
//   dout_valid  one-cycle strobe, one clock after the completing sample
// ----------------------------------------------------------------------------
module integrator_dec #(
  parameter int DIN_WIDTH  = 9,
  parameter int ACC_WIDTH  = 24,
  parameter int DOUT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  input  logic                         clear,
  input  logic        [31:0]           decimation,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid
);

  // Sign-extend a sample to accumulator width. The later addition wraps
  // modulo 2^ACC_WIDTH. This is intentional for CIC operation, so the sum
  // is never saturated.
  function automatic logic signed [ACC_WIDTH-1:0] sign_ext(
    input logic signed [DIN_WIDTH-1:0] x
  );
    return ACC_WIDTH'(x);
  endfunction

  // Truncate the accumulator to its top DOUT_WIDTH bits. The low bits are
  // discarded without rounding.
  function automatic logic signed [DOUT_WIDTH-1:0] top_bits(
    input logic signed [ACC_WIDTH-1:0] a
  );
    return a[ACC_WIDTH-1 -: DOUT_WIDTH];
  endfunction

  logic        [31:0]           dec_q, dec_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic        [31:0]           cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;

  logic        [31:0]           dec_eff;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic                         emit;

  always_comb begin
    dec_d        = decimation;
    dec_eff      = (dec_q == 32'd0) ? 32'd1 : dec_q;
    acc_next     = acc_q + sign_ext(din);
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    emit         = 1'b0;

    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (din_valid) begin
      acc_d = acc_next;
      // The >= compare handles a ratio that shrinks below the current count.
      // In that case the next valid sample closes the block immediately, so
      // the counter never overruns.
      if (cnt_q >= dec_eff - 32'd1) begin
        cnt_d = '0;
        emit  = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    dout_d       = emit ? top_bits(acc_next) : dout_q;
    dout_valid_d = emit;
  end

  // ---- register stage: accumulator, counter and output ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_q        <= 32'd1;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dec_q        <= dec_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_integrator_dec.sv
module tb_integrator_dec;

  localparam int DA_W = 12;
  localparam int AA_W = 24;
  localparam int OA_W = 16;
  localparam int B_W  = 9;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A: 24-bit accumulator, 16-bit output
  logic signed [DA_W-1:0] din_a;
  logic                   dv_a, clr_a;
  logic        [31:0]     dec_a;
  logic signed [OA_W-1:0] dout_a;
  logic                   vout_a;

  // DUT B: 9-bit everything, exposes wrap directly
  logic signed [B_W-1:0]  din_b;
  logic                   dv_b, clr_b;
  logic        [31:0]     dec_b;
  logic signed [B_W-1:0]  dout_b;
  logic                   vout_b;

  integrator_dec #(.DIN_WIDTH(DA_W), .ACC_WIDTH(AA_W), .DOUT_WIDTH(OA_W)) u_a (
    .clk(clk), .rst(rst_n), .din(din_a), .din_valid(dv_a), .clear(clr_a),
    .decimation(dec_a), .dout(dout_a), .dout_valid(vout_a)
  );

  integrator_dec #(.DIN_WIDTH(B_W), .ACC_WIDTH(B_W), .DOUT_WIDTH(B_W)) u_b (
    .clk(clk), .rst(rst_n), .din(din_b), .din_valid(dv_b), .clear(clr_b),
    .decimation(dec_b), .dout(dout_b), .dout_valid(vout_b)
  );

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every dout_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (vout_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_valid: got dout=%0d expected no strobe", dout_a);
      end else begin
        chk("a_dout", int'(dout_a), qa.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (vout_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_valid: got dout=%0d expected no strobe", dout_b);
      end else begin
        chk("b_dout", int'(dout_b), qb.pop_front());
      end
    end
  end

  // One clock of stimulus on DUT A; e/ex queue the expected emission.
  task automatic cyc_a(input logic v, input int d, input logic clr,
                       input logic e, input int ex);
    din_a = DA_W'(d); dv_a = v; clr_a = clr;
    if (e) qa.push_back(ex);
    @(posedge clk); #1;
    dv_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic cyc_b(input logic v, input int d, input logic clr,
                       input logic e, input int ex);
    din_b = B_W'(d); dv_b = v; clr_b = clr;
    if (e) qb.push_back(ex);
    @(posedge clk); #1;
    dv_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    din_a = DA_W'(100); dv_a = 1'b1; clr_a = 1'b0; dec_a = 32'd4;
    din_b = B_W'(100);  dv_b = 1'b1; clr_b = 1'b0; dec_b = 32'd1;
    #1;
    chk("rst_dout_a",  int'(dout_a), 0);
    chk("rst_valid_a", int'(vout_a), 0);
    chk("rst_dout_b",  int'(dout_b), 0);
    chk("rst_valid_b", int'(vout_b), 0);
    // Samples offered during reset must be ignored.
    @(posedge clk); @(posedge clk); #1;
    dv_a = 1'b0; dv_b = 1'b0;
    rst_n = 1'b1;
    idle(1);

    // Ratio 4, +256 x8: sums 1024, 2048 -> top 16 of 24 bits = 4, 8
    for (int i = 1; i <= 8; i++)
      cyc_a(1'b1, 256, 1'b0, (i % 4) == 0, (i == 4) ? 4 : 8);
    // Gaps with junk on din must not disturb acc = 2048
    cyc_a(1'b0, 77, 1'b0, 1'b0, 0);
    cyc_a(1'b0, -9, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++)
      cyc_a(1'b1, 0, 1'b0, i == 4, 8);

    // Gapped valid, ratio 2: 2048+256+512=2816 -> 11; 2816-512=2304 -> 9
    dec_a = 32'd2; idle(1);
    cyc_a(1'b1, 256,  1'b0, 1'b0, 0);
    cyc_a(1'b0, 999,  1'b0, 1'b0, 0);
    cyc_a(1'b1, 512,  1'b0, 1'b1, 11);
    cyc_a(1'b0, 999,  1'b0, 1'b0, 0);
    cyc_a(1'b1, -256, 1'b0, 1'b0, 0);
    cyc_a(1'b0, 0,    1'b0, 1'b0, 0);
    cyc_a(1'b1, -256, 1'b0, 1'b1, 9);
    cyc_a(1'b0, 0,    1'b0, 1'b0, 0);

    // Ratio 8, five samples (cnt=5, acc=3584), then ratio 3
    dec_a = 32'd8; idle(1);
    for (int i = 0; i < 5; i++) cyc_a(1'b1, 256, 1'b0, 1'b0, 0);
    dec_a = 32'd3; idle(1);
    cyc_a(1'b1, 256, 1'b0, 1'b1, 15);          // 3840
    for (int i = 1; i <= 3; i++)
      cyc_a(1'b1, 256, 1'b0, i == 3, 18);      // 4608
    for (int i = 1; i <= 3; i++)
      cyc_a(1'b1, -256, 1'b0, i == 3, 15);     // 3840

    // Ratio 0 behaves as 1: emit every sample
    dec_a = 32'd0; idle(1);
    cyc_a(1'b1, 256, 1'b0, 1'b1, 16);          // 4096
    cyc_a(1'b1, 256, 1'b0, 1'b1, 17);          // 4352
    // Clear right after an emission keeps that emission's strobe
    cyc_a(1'b1, 256, 1'b0, 1'b1, 18);          // 4608
    cyc_a(1'b0, 0,   1'b1, 1'b0, 0);           // acc -> 0
    cyc_a(1'b1, 512, 1'b0, 1'b1, 2);           // 512 after clear

    // DUT B: wrap at 9 bits, ratio 1: 255 -> 255, 510 -> -2
    cyc_b(1'b1, 255, 1'b0, 1'b1, 255);
    cyc_b(1'b1, 255, 1'b0, 1'b1, -2);
    // Clear collision at ratio 4: partial sum and colliding sample dropped
    dec_b = 32'd4; idle(1);
    for (int i = 0; i < 3; i++) cyc_b(1'b1, 1, 1'b0, 1'b0, 0);
    cyc_b(1'b1, 5, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 4; i++) cyc_b(1'b1, 1, 1'b0, i == 4, 4);
    idle(2);

    // Asynchronous reset mid-block on A: acc holds 512+512 = 1024, cnt = 2
    dec_a = 32'd4; idle(1);
    cyc_a(1'b1, 256, 1'b0, 1'b0, 0);
    cyc_a(1'b1, 256, 1'b0, 1'b0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_dout_a",  int'(dout_a), 0);
    chk("async_valid_a", int'(vout_a), 0);
    chk("async_dout_b",  int'(dout_b), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);
    // A fresh block needs four full samples; the old partial sum is gone.
    for (int i = 1; i <= 4; i++)
      cyc_a(1'b1, 256, 1'b0, i == 4, 4);
    idle(3);

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
